sum_arb: RTL

Round-robin arbiter and sequencer that shares one W-bit add/sub datapath among NUM_REQ requesters. Each requester presents an operation under a valid/ready handshake. The block grants one requester at a time, registers its operands, and computes the result and status flags. It then returns them on a single response port with backpressure, tagged with the requester index. It sits between the client blocks and the arithmetic core, which is not instantiated anywhere else.

---
 rtl/sum_pkg.sv | 13 +
 rtl/sum_arb_addsub_core.sv | 28 ++
 rtl/sum_arb.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sum_pkg.sv
// Shared types and constants for the sum_arb arbiter/sequencer.
package sum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/sum_arb_addsub_core.sv
// Combinational W-bit add/sub datapath with carry and signed-overflow flags.
// For subtraction carry is the inverted borrow (1 = no borrow).
module addsub_core
  import sum_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] b_mod;
  logic [WIDTH:0]   sum;

  // Two's-complement subtract: invert B and inject the select as carry-in.
  always_comb begin
    b_mod  = (sel == OP_SUB) ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_mod} + {{WIDTH{1'b0}}, sel};
    result = sum[WIDTH-1:0];
    carry  = sum[WIDTH];
    ovf    = (a[WIDTH-1] == b_mod[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/sum_arb.sv
// Round-robin arbiter that shares one add/sub datapath among NUM_REQ
// requesters. One op in flight: accept (IDLE) -> compute (EXEC) -> respond
// (RESP, held under backpressure).
//
//   state | meaning
//   IDLE  | grant offered to the round-robin winner, waiting for a request
//   EXEC  | latched operands feed the datapath, result captured at cycle end
//   RESP  | response valid and frozen until resp_ready
module sum_arb
  import sum_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_sel,
  input  logic [NUM_REQ*WIDTH-1:0] req_src1,
  input  logic [NUM_REQ*WIDTH-1:0] req_src2,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [WIDTH-1:0]         resp_result,
  output logic                     resp_carry,
  output logic                     resp_ovf,
  output logic                     resp_zero
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   grant;
  logic             any_valid;
  logic             accept;

  logic             sel_mux;
  logic [WIDTH-1:0] a_mux, b_mux;

  logic             op_sel_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [IDW-1:0]   op_id_q;

  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_carry_q, rsp_ovf_q, rsp_zero_q;

  logic [WIDTH-1:0] core_result;
  logic             core_carry, core_ovf;

  // First valid index at or above start, else wrap to the lowest valid index.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     start);
    logic [IDW-1:0] pick;
    logic           found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i] && (IDW'(i) >= start)) begin
        pick  = IDW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i]) begin
        pick  = IDW'(i);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign any_valid = |req_valid;
  assign grant     = rr_pick(req_valid, ptr_q);
  assign accept    = |(req_valid & req_ready);

  // Pointer advances to the slot just past the winner.
  always_comb begin
    if (grant == IDW'(NUM_REQ - 1)) ptr_d = '0;
    else                            ptr_d = grant + 1'b1;
  end

  // Route the granted requester's op onto the capture bus.
  always_comb begin
    sel_mux = 1'b0;
    a_mux   = '0;
    b_mux   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_mux = req_sel[i];
        a_mux   = req_src1[i*WIDTH +: WIDTH];
        b_mux   = req_src2[i*WIDTH +: WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; the grant is withheld while reset is asserted.
  always_comb begin
    req_ready  = '0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE:    if (!rst && any_valid) req_ready[grant] = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operands are sampled only in the accept cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      op_sel_q <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_id_q  <= '0;
    end else if (accept) begin
      ptr_q    <= ptr_d;
      op_sel_q <= sel_mux;
      op_a_q   <= a_mux;
      op_b_q   <= b_mux;
      op_id_q  <= grant;
    end
  end

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .sel    (op_sel_q),
    .a      (op_a_q),
    .b      (op_b_q),
    .result (core_result),
    .carry  (core_carry),
    .ovf    (core_ovf)
  );

  // Response registers load once at the end of EXEC and hold through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_id_q     <= op_id_q;
      rsp_result_q <= core_result;
      rsp_carry_q  <= core_carry;
      rsp_ovf_q    <= core_ovf;
      rsp_zero_q   <= (core_result == '0);
    end
  end

  assign resp_id     = rsp_id_q;
  assign resp_result = rsp_result_q;
  assign resp_carry  = rsp_carry_q;
  assign resp_ovf    = rsp_ovf_q;
  assign resp_zero   = rsp_zero_q;

endmodule
